// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the multi-port register file.
package reg_file_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 4;
    localparam int RF_NUM_REGS = 15;
    localparam int RF_NUM_RD   = 2;

    // Bits needed to index n registers; never less than one.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/reg_file_init_ctrl.sv
// Initialisation sweep sequencer: walks idx through every register after
// reset or an init request, then parks in READY.
module reg_file_init_ctrl
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int IDX_W    = idx_width(RF_NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_req,
    output rf_state_e        state,
    output logic [IDX_W-1:0] idx,
    output logic             init_we,
    output logic             ready
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    rf_state_e        state_next;
    logic [IDX_W-1:0] idx_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= INIT;
            idx   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            ready <= (state_next == READY);
        end
    end

    // init_req is only honoured from READY; an ongoing sweep always completes.
    always_comb begin
        state_next = state;
        idx_next   = '0;
        case (state)
            INIT: begin
                if (idx == LAST_IDX) begin
                    state_next = READY;
                end else begin
                    idx_next = idx + IDX_W'(1);
                end
            end
            READY: begin
                if (init_req) begin
                    state_next = INIT;
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        init_we = (state == INIT);
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read, dual-write register file with a self-initialising sweep and
// same-cycle write-to-read bypass.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = RF_NUM_RD
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           init_req,
    input  logic                           wb_en0,
    input  logic                           wb_en1,
    input  logic [ADDR_W-1:0]              wb_dest0,
    input  logic [ADDR_W-1:0]              wb_dest1,
    input  logic [DATA_W-1:0]              wb_val0,
    input  logic [DATA_W-1:0]              wb_val1,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd_val,
    output logic                           ready
);

    localparam int               IDX_W    = idx_width(NUM_REGS);
    localparam logic [ADDR_W:0]  REGS_LIM = (ADDR_W + 1)'(NUM_REGS);

    rf_state_e        state;
    logic [IDX_W-1:0] idx;
    logic             init_we;
    logic             wr_ok0;
    logic             wr_ok1;

    logic [DATA_W-1:0] mem [NUM_REGS];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < REGS_LIM);
    endfunction

    reg_file_init_ctrl #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_init_ctrl (
        .clk      (clk),
        .rst      (rst),
        .init_req (init_req),
        .state    (state),
        .idx      (idx),
        .init_we  (init_we),
        .ready    (ready)
    );

    // Qualified write strobes feed both the array and the bypass, so a write
    // dropped by reset, INIT or a bad address is never visible on a read port.
    always_comb begin
        wr_ok0 = rst && (state == READY) && wb_en0 && in_range(wb_dest0);
        wr_ok1 = rst && (state == READY) && wb_en1 && in_range(wb_dest1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (init_we) begin
                mem[idx] <= DATA_W'(idx);
            end else begin
                if (wr_ok0) begin
                    mem[wb_dest0[IDX_W-1:0]] <= wb_val0;
                end
                // Port 1 is applied last so it wins on an address collision.
                if (wr_ok1) begin
                    mem[wb_dest1[IDX_W-1:0]] <= wb_val1;
                end
            end
        end
    end

    always_comb begin
        rd_val = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            if (in_range(rd_addr[k])) begin
                rd_val[k] = mem[rd_addr[k][IDX_W-1:0]];
            end
            if (wr_ok0 && (rd_addr[k] == wb_dest0)) begin
                rd_val[k] = wb_val0;
            end
            if (wr_ok1 && (rd_addr[k] == wb_dest1)) begin
                rd_val[k] = wb_val1;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed, table-driven bench for reg_file_mp at default and reduced sizing.
module tb_reg_file_mp;

    logic clk;
    logic rst;
    logic init_req;

    logic             wb_en0, wb_en1;
    logic [3:0]       wb_dest0, wb_dest1;
    logic [31:0]      wb_val0, wb_val1;
    logic [1:0][3:0]  rd_addr1;
    logic [1:0][31:0] rd_val1;
    logic             ready1;

    logic             w2_en0, w2_en1;
    logic [3:0]       w2_dest0, w2_dest1;
    logic [15:0]      w2_val0, w2_val1;
    logic [2:0][3:0]  rd_addr2;
    logic [2:0][15:0] rd_val2;
    logic             ready2;

    int tests;
    int fails;

    typedef struct {
        logic        wen0;
        logic [3:0]  d0;
        logic [31:0] v0;
        logic        wen1;
        logic [3:0]  d1;
        logic [31:0] v1;
        logic [3:0]  r0;
        logic [3:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    localparam int NV = 11;
    vec_t        vecs [NV];
    logic [31:0] exp_regs [15];

    reg_file_mp #(
        .DATA_W   (32),
        .ADDR_W   (4),
        .NUM_REGS (15),
        .NUM_RD   (2)
    ) dut1 (
        .clk      (clk),
        .rst      (rst),
        .init_req (init_req),
        .wb_en0   (wb_en0),
        .wb_en1   (wb_en1),
        .wb_dest0 (wb_dest0),
        .wb_dest1 (wb_dest1),
        .wb_val0  (wb_val0),
        .wb_val1  (wb_val1),
        .rd_addr  (rd_addr1),
        .rd_val   (rd_val1),
        .ready    (ready1)
    );

    reg_file_mp #(
        .DATA_W   (16),
        .ADDR_W   (4),
        .NUM_REGS (8),
        .NUM_RD   (3)
    ) dut2 (
        .clk      (clk),
        .rst      (rst),
        .init_req (1'b0),
        .wb_en0   (w2_en0),
        .wb_en1   (w2_en1),
        .wb_dest0 (w2_dest0),
        .wb_dest1 (w2_dest1),
        .wb_val0  (w2_val0),
        .wb_val1  (w2_val1),
        .rd_addr  (rd_addr2),
        .rd_val   (rd_val2),
        .ready    (ready2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Samples ready on both instances for k = 0..15 cycles after the sweep starts.
    task automatic watch_ready(input int n1, input int n2, input string tag);
        for (int k = 0; k <= 15; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            check($sformatf("%s.ready1@%0d", tag, k), {31'd0, ready1}, {31'd0, (k >= n1)});
            check($sformatf("%s.ready2@%0d", tag, k), {31'd0, ready2}, {31'd0, (k >= n2)});
        end
    endtask

    task automatic clear_writes();
        wb_en0 = 1'b0; wb_en1 = 1'b0;
        wb_dest0 = '0; wb_dest1 = '0;
        wb_val0 = '0;  wb_val1 = '0;
    endtask

    initial begin
        tests = 0;
        fails = 0;

        vecs[0]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        4'd3,  4'd14, 32'd3,        32'd14};
        vecs[1]  = '{1'b1, 4'd5,  32'hAAAA0000, 1'b1, 4'd5,  32'h5555FFFF, 4'd5,  4'd0,  32'h5555FFFF, 32'd0};
        vecs[2]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        4'd5,  4'd5,  32'h5555FFFF, 32'h5555FFFF};
        vecs[3]  = '{1'b1, 4'd7,  32'h12345678, 1'b0, 4'd0,  32'h0,        4'd7,  4'd15, 32'h12345678, 32'd0};
        vecs[4]  = '{1'b1, 4'd15, 32'hFFFFFFFF, 1'b1, 4'd15, 32'hEEEEEEEE, 4'd15, 4'd7,  32'd0,        32'h12345678};
        vecs[5]  = '{1'b1, 4'd4,  32'h44,       1'b1, 4'd3,  32'h33,       4'd3,  4'd4,  32'h33,       32'h44};
        vecs[6]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        4'd3,  4'd4,  32'h33,       32'h44};
        vecs[7]  = '{1'b1, 4'd1,  32'h11,       1'b1, 4'd2,  32'h22,       4'd1,  4'd2,  32'h11,       32'h22};
        vecs[8]  = '{1'b1, 4'd0,  32'hFFFFFFFF, 1'b0, 4'd0,  32'h0,        4'd0,  4'd14, 32'hFFFFFFFF, 32'd14};
        vecs[9]  = '{1'b0, 4'd6,  32'hBAD,      1'b0, 4'd6,  32'hBAD2,     4'd6,  4'd6,  32'd6,        32'd6};
        vecs[10] = '{1'b1, 4'd8,  32'h88,       1'b1, 4'd9,  32'h99,       4'd8,  4'd9,  32'h88,       32'h99};

        for (int i = 0; i < 15; i++) exp_regs[i] = i;
        exp_regs[0] = 32'hFFFFFFFF; exp_regs[1] = 32'h11;       exp_regs[2] = 32'h22;
        exp_regs[3] = 32'h33;       exp_regs[4] = 32'h44;       exp_regs[5] = 32'h5555FFFF;
        exp_regs[7] = 32'h12345678; exp_regs[8] = 32'h88;       exp_regs[9] = 32'h99;

        rst = 1'b0;
        init_req = 1'b0;
        clear_writes();
        rd_addr1 = '0;
        w2_en0 = 1'b0; w2_en1 = 1'b0; w2_dest0 = '0; w2_dest1 = '0; w2_val0 = '0; w2_val1 = '0;
        rd_addr2[0] = 4'd0; rd_addr2[1] = 4'd7; rd_addr2[2] = 4'd9;

        repeat (3) @(negedge clk);
        #1;
        check("reset.ready1", {31'd0, ready1}, 32'd0);
        check("reset.ready2", {31'd0, ready2}, 32'd0);

        rst = 1'b1;
        watch_ready(15, 8, "boot");
        check("p2.rd0", {16'd0, rd_val2[0]}, 32'd0);
        check("p2.rd1", {16'd0, rd_val2[1]}, 32'd7);
        check("p2.rd2", {16'd0, rd_val2[2]}, 32'd0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            wb_en0 = vecs[i].wen0; wb_dest0 = vecs[i].d0; wb_val0 = vecs[i].v0;
            wb_en1 = vecs[i].wen1; wb_dest1 = vecs[i].d1; wb_val1 = vecs[i].v1;
            rd_addr1[0] = vecs[i].r0;
            rd_addr1[1] = vecs[i].r1;
            #1;
            check($sformatf("vec%0d.rd0", i), rd_val1[0], vecs[i].e0);
            check($sformatf("vec%0d.rd1", i), rd_val1[1], vecs[i].e1);
        end

        @(negedge clk);
        clear_writes();
        for (int i = 0; i < 15; i++) begin
            rd_addr1[0] = 4'(i);
            rd_addr1[1] = 4'(14 - i);
            #1;
            check($sformatf("regs.r%0d", i), rd_val1[0], exp_regs[i]);
            check($sformatf("regs.r%0d", 14 - i), rd_val1[1], exp_regs[14 - i]);
        end

        // init_req from READY; held high through INIT, where it must be ignored.
        @(negedge clk);
        wb_en0 = 1'b1; wb_dest0 = 4'd2; wb_val0 = 32'hDEAD;
        rd_addr1[0] = 4'd2; rd_addr1[1] = 4'd5;
        #1;
        check("ireq.bypass", rd_val1[0], 32'hDEAD);
        @(negedge clk);
        clear_writes();
        init_req = 1'b1;
        #1;
        check("ireq.stored", rd_val1[0], 32'hDEAD);
        @(negedge clk);
        wb_en0 = 1'b1; wb_dest0 = 4'd2; wb_val0 = 32'hBEEF;
        wb_en1 = 1'b1; wb_dest1 = 4'd5; wb_val1 = 32'h77;
        #1;
        check("ireq.nobypass0", rd_val1[0], 32'hDEAD);
        check("ireq.nobypass1", rd_val1[1], 32'h5555FFFF);
        watch_ready(15, 0, "ireq");
        init_req = 1'b0;
        clear_writes();
        #1;
        check("ireq.r2", rd_val1[0], 32'd2);
        check("ireq.r5", rd_val1[1], 32'd5);

        // Reset over a pending write, then a second reset six cycles into the sweep.
        @(negedge clk);
        rst = 1'b0;
        wb_en0 = 1'b1; wb_dest0 = 4'd9; wb_val0 = 32'hCAFE;
        rd_addr1[0] = 4'd9;
        @(negedge clk);
        rst = 1'b1;
        clear_writes();
        #1;
        check("rst.discard", rd_val1[0], 32'd9);
        check("rst.ready", {31'd0, ready1}, 32'd0);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        watch_ready(15, 8, "midrst");

        for (int i = 0; i < 15; i++) begin
            rd_addr1[0] = 4'(i);
            #1;
            check($sformatf("final.r%0d", i), rd_val1[0], i);
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr2[0] = 4'(i);
            #1;
            check($sformatf("final.p2r%0d", i), {16'd0, rd_val2[0]}, i);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, data width of each register.
REQ-002 SHALL provide parameter ADDR_W, default 4, width of every address port.
REQ-003 SHALL provide parameter NUM_REGS, default 15, number of implemented registers, legal range 2..2**ADDR_W.
REQ-004 SHALL provide parameter NUM_RD, default 2, number of read ports, legal range 1..4.
REQ-005 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL provide port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL provide port init_req  input  1  request to re-run the initialisation sweep.
REQ-008 SHALL provide ports wb_en0, wb_en1  input  1 each  write enables, ports 0 and 1.
REQ-009 SHALL provide ports wb_dest0, wb_dest1  input  ADDR_W each  write addresses.
REQ-010 SHALL provide ports wb_val0, wb_val1  input  DATA_W each  write data.
REQ-011 SHALL provide port rd_addr  input  NUM_RD x ADDR_W  read addresses, one per port.
REQ-012 SHALL provide port rd_val  output  NUM_RD x DATA_W  read data, one per port.
REQ-013 SHALL provide port ready  output  1  high when the file accepts writes and bypasses.

Function
REQ-014 SHALL implement a two-state FSM: INIT, READY.
REQ-015 In INIT, SHALL write register idx with idx zero-extended to DATA_W, one register per cycle, starting at idx 0.
REQ-016 SHALL move INIT->READY on the cycle that writes idx NUM_REGS-1; INIT lasts exactly NUM_REGS cycles.
REQ-017 SHALL move READY->INIT, with idx reset to 0, on the cycle after init_req is sampled high in READY.
REQ-018 SHALL ignore init_req while in INIT; the sweep is not restarted.
REQ-019 ready SHALL be a registered output equal to 1 iff state is READY.
REQ-020 In READY, SHALL write wb_val0 to wb_dest0 when wb_en0 is high, and wb_val1 to wb_dest1 when wb_en1 is high, at the rising edge.
REQ-021 When both ports write the same address in one cycle, port 1 SHALL win.
REQ-022 In INIT, SHALL discard wb_en0/wb_en1 writes.
REQ-023 Writes with address >= NUM_REGS SHALL be discarded without side effect.
REQ-024 rd_val[k] SHALL be combinational from rd_addr[k] with zero cycles latency.
REQ-025 rd_val[k] SHALL return 0 for rd_addr[k] >= NUM_REGS.
REQ-026 In READY, rd_val[k] SHALL bypass same-cycle write data when rd_addr[k] matches an enabled in-range write address, with port 1 taking priority over port 0.
REQ-027 In INIT, rd_val[k] SHALL return stored array contents, with no bypass.

Reset
REQ-028 When rst is low at a rising edge, SHALL enter INIT with idx=0 and ready=0 on the next cycle.
REQ-029 Reset asserted mid-sweep or mid-write SHALL restart the sweep from idx 0; the pending write is discarded.
REQ-030 Register contents are undefined after reset until the sweep has written them.

Structure
REQ-031 SHALL place the state enum (INIT, READY) and the default parameter constants in package reg_file_pkg.
REQ-032 SHALL implement the sweep FSM and idx counter in sub-module reg_file_init_ctrl, with outputs state, idx and init_we.
REQ-033 The storage array, write arbitration and bypass muxes SHALL reside in reg_file_mp.

Verification
REQ-034 Reset release, default parameters:
- ready=0 for 15 cycles, then 1.
- Then rd_addr={3,14} -> rd_val={3,14}.

REQ-035 Dual write, same address:
- READY, wb_en0=wb_en1=1, dest0=dest1=5, val0=0xAAAA0000, val1=0x5555FFFF.
- Same-cycle rd_addr=5 -> 0x5555FFFF.
- Next cycle with no write -> 0x5555FFFF.

REQ-036 Bypass and out-of-range:
- wb_en0=1, dest0=7, val0=0x12345678, rd_addr={7,15}.
- Same cycle -> rd_val={0x12345678,0}.
- Write to address 15 -> no change to any register.

REQ-037 init_req in READY:
- Write reg 2=0xDEAD, then pulse init_req.
- ready drops next cycle.
- Writes during INIT ignored; after 15 cycles rd reg 2 -> 2.

REQ-038 Reset mid-sweep:
- rst low at sweep cycle 6.
- Sweep restarts from idx 0; ready rises exactly 15 cycles after rst returns high.

REQ-039 Parameter set DATA_W=16, NUM_REGS=8, NUM_RD=3:
- ready after 8 cycles.
- rd_addr={0,7,9} -> {0,7,0}.
